order_rx: RTL and testbench

ORDER_RX -- requirements
Module: order_rx

---
 rtl/order_rx.sv | 101 ++++++++++
 tb/tb_order_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/order_rx.sv
// Order packet receiver: decodes BUY/SELL packets into a small FIFO, flags bad and dropped packets.
// Define ORDER_RX_POSITION_EN to build the saturating net-position tracker; otherwise net_position is 0.
module order_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int POS_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             order_packet,
  input  logic                    order_valid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_side,
  output logic [15:0]             out_qty,
  output logic                    bad_opcode,
  output logic                    overflow,
  output logic [15:0]             err_cnt,
  output logic signed [POS_W-1:0] net_position
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0] OP_BUY  = 16'hB001;
  localparam logic [15:0] OP_SELL = 16'hC001;

  logic [16:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             is_buy, is_sell, good, bad, full, pop, push, drop;

  always_comb begin
    is_buy  = (order_packet[31:16] == OP_BUY);
    is_sell = (order_packet[31:16] == OP_SELL);
    good    = order_valid && (is_buy || is_sell) && (order_packet[15:0] != 16'd0);
    bad     = order_valid && !good;
    full    = (count == CNT_W'(FIFO_DEPTH));
    pop     = out_valid && out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push    = good && (!full || pop);
    drop    = good && full && !pop;
  end

  assign out_valid = (count != '0);
  // Head is forced to zero when empty so the outputs have a defined reset value.
  assign out_side  = out_valid ? mem[rd_ptr][16]   : 1'b0;
  assign out_qty   = out_valid ? mem[rd_ptr][15:0] : 16'd0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {is_sell, order_packet[15:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      bad_opcode <= 1'b0;
      overflow   <= 1'b0;
      err_cnt    <= 16'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      bad_opcode <= bad;
      overflow   <= drop;
      if ((bad || drop) && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 1'b1;
    end
  end

`ifdef ORDER_RX_POSITION_EN
  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  logic signed [POS_W:0] qty_ext, pos_sum;

  always_comb begin
    qty_ext = $signed({{(POS_W+1-16){1'b0}}, out_qty});
    pos_sum = out_side ? ({net_position[POS_W-1], net_position} - qty_ext)
                       : ({net_position[POS_W-1], net_position} + qty_ext);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      net_position <= '0;
    end else if (pop) begin
      // Top two bits disagree only when the result left the POS_W range.
      if (pos_sum[POS_W] != pos_sum[POS_W-1])
        net_position <= pos_sum[POS_W] ? POS_MIN : POS_MAX;
      else
        net_position <= pos_sum[POS_W-1:0];
    end
  end
`else
  assign net_position = '0;
`endif

endmodule

// File: tb/tb_order_rx.sv
// Self-checking bench for order_rx: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_order_rx;
  localparam int FIFO_DEPTH = 4;
  localparam int POS_W      = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [31:0]             order_packet;
  logic                    order_valid;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_side;
  logic [15:0]             out_qty;
  logic                    bad_opcode;
  logic                    overflow;
  logic [15:0]             err_cnt;
  logic signed [POS_W-1:0] net_position;

  order_rx #(.FIFO_DEPTH(FIFO_DEPTH), .POS_W(POS_W)) dut (
    .clk(clk), .rst(rst), .order_packet(order_packet), .order_valid(order_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_side(out_side), .out_qty(out_qty),
    .bad_opcode(bad_opcode), .overflow(overflow), .err_cnt(err_cnt), .net_position(net_position)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ORDER_RX_POSITION_EN
  localparam bit POS_EN = 1'b1;
`else
  localparam bit POS_EN = 1'b0;
`endif

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {sell, qty} plus counters, updated once per clock.
  logic [16:0] q[$];
  longint      m_err, m_pos;
  bit          m_bad, m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_err = 0; m_pos = 0; m_bad = 0; m_ovf = 0;
    end else begin
      bit was_full, popped, ok;
      logic [16:0] head;
      was_full = (q.size() == FIFO_DEPTH);
      popped   = (q.size() > 0) && out_ready;
      if (popped) begin
        head = q.pop_front();
        m_pos = head[16] ? m_pos - longint'(head[15:0]) : m_pos + longint'(head[15:0]);
        if (m_pos > (64'sd1 <<< (POS_W-1)) - 1) m_pos = (64'sd1 <<< (POS_W-1)) - 1;
        if (m_pos < -(64'sd1 <<< (POS_W-1)))    m_pos = -(64'sd1 <<< (POS_W-1));
      end
      m_bad = 0; m_ovf = 0;
      if (order_valid) begin
        ok = (order_packet[31:16] == 16'hB001 || order_packet[31:16] == 16'hC001)
             && order_packet[15:0] != 16'd0;
        if (!ok) m_bad = 1;
        else if (was_full && !popped) m_ovf = 1;
        else q.push_back({order_packet[31:16] == 16'hC001, order_packet[15:0]});
        if ((m_bad || m_ovf) && m_err < 65535) m_err++;
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", out_valid, q.size() != 0);
    check("out_side", out_side, q.size() != 0 ? q[0][16] : 1'b0);
    check("out_qty", out_qty, q.size() != 0 ? q[0][15:0] : 16'd0);
    check("bad_opcode", bad_opcode, m_bad);
    check("overflow", overflow, m_ovf);
    check("err_cnt", err_cnt, m_err);
    check("net_position", longint'(net_position), POS_EN ? m_pos : 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] op, input logic [15:0] qty);
    order_packet = {op, qty};
    order_valid  = 1'b1;
  endtask

  initial begin
    rst = 1'b1; order_packet = '0; order_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_out_qty", out_qty, 0);
    rst = 1'b0;

    // Single BUY then SELL with a ready consumer
    out_ready = 1'b1;
    send(16'hB001, 16'd100); tick();
    check("buy_valid", out_valid, 1);
    check("buy_side", out_side, 0);
    check("buy_qty", out_qty, 100);
    order_valid = 1'b0; tick();
    check("buy_pos", longint'(net_position), POS_EN ? 100 : 0);
    check("buy_empty", out_valid, 0);
    send(16'hC001, 16'd50); tick();
    check("sell_side", out_side, 1);
    check("sell_qty", out_qty, 50);
    order_valid = 1'b0; tick();
    check("sell_pos", longint'(net_position), POS_EN ? 50 : 0);

    // Unknown opcode and zero quantity
    send(16'hDEAD, 16'd5); tick();
    check("bad1_pulse", bad_opcode, 1);
    check("bad1_err", err_cnt, 1);
    send(16'hB001, 16'd0); tick();
    check("bad2_pulse", bad_opcode, 1);
    check("bad2_err", err_cnt, 2);
    check("bad2_valid", out_valid, 0);
    order_valid = 1'b0; tick();
    check("bad_clear", bad_opcode, 0);

    // Overflow with a stalled consumer, then in-order drain
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send(16'hB001, 16'(k)); tick();
    end
    check("ovf_pulse", overflow, 1);
    check("ovf_err", err_cnt, 3);
    order_valid = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_qty", out_qty, k);
      tick();
    end
    check("drain_empty", out_valid, 0);
    check("drain_pos", longint'(net_position), POS_EN ? 60 : 0);

    // Push into a full FIFO while the head is popped
    out_ready = 1'b0;
    for (int k = 11; k <= 14; k++) begin
      send(16'hB001, 16'(k)); tick();
    end
    out_ready = 1'b1;
    send(16'hB001, 16'd15); tick();
    check("fullpop_ovf", overflow, 0);
    check("fullpop_err", err_cnt, 3);
    order_valid = 1'b0;
    for (int k = 12; k <= 15; k++) begin
      check("fullpop_qty", out_qty, k);
      tick();
    end
    check("fullpop_empty", out_valid, 0);
    check("fullpop_pos", longint'(net_position), POS_EN ? 125 : 0);

    // Asynchronous reset with orders queued, and an order offered during reset
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      send(16'hC001, 16'(k)); tick();
    end
    order_valid = 1'b0;
    #2;
    rst = 1'b1;
    send(16'hB001, 16'hAA);
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_err", err_cnt, 0);
    check("arst_pos", longint'(net_position), 0);
    tick(); tick();
    check("arst_ignored", out_valid, 0);
    rst = 1'b0;
    send(16'hB001, 16'd7); tick();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_qty", out_qty, 7);
    order_valid = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [15:0] op, qty;
      sel = $urandom_range(0, 3);
      op  = (sel < 2) ? 16'hB001 : (sel == 2) ? 16'hC001 : 16'($urandom);
      qty = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      order_packet = {op, qty};
      order_valid  = $urandom_range(0, 1) == 1;
      out_ready    = $urandom_range(0, 9) < 6;
      tick();
    end
    order_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
